// File: rtl/microwave_ctrl.sv
// Single-clock microwave cook-timer sequencer: load, prescaled countdown,
// door interlock, pause/resume, cancel, quick-add and a timed completion beep.
module microwave_ctrl #(
   parameter int TICK_DIV = 4,
   parameter int BEEP_LEN = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] tin,
   input  logic       set,
   input  logic       start,
   input  logic       stop,
   input  logic       door,
   output logic       p,
   output logic [3:0] remain,
   output logic       beep,
   output logic [2:0] state
);
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BEEP_CYC = BEEP_LEN * TICK_DIV;
   localparam int BW       = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_SET   = 3'b001,
      ST_COOK  = 3'b010,
      ST_PAUSE = 3'b011,
      ST_DONE  = 3'b100
   } state_t;

   state_t        r_state;
   logic          r_p;
   logic          r_beep;
   logic [3:0]    r_remain;
   logic [PW-1:0] r_pre;
   logic [BW-1:0] r_bcnt;
   logic          r_set_prev;
   logic          r_start_prev;
   logic          r_stop_prev;

   logic          w_set_ev;
   logic          w_start_ev;
   logic          w_stop_ev;
   logic          w_term;
   logic [PW-1:0] w_pre_nxt;
   logic          w_last_unit;
   logic [3:0]    w_rem_dec;
   logic [3:0]    w_rem_inc;

   assign w_set_ev    = set & ~r_set_prev;
   assign w_start_ev  = start & ~r_start_prev;
   assign w_stop_ev   = stop & ~r_stop_prev;
   assign w_term      = (r_pre == PRE_LAST);
   assign w_pre_nxt   = w_term ? {PW{1'b0}} : r_pre + PW'(1);
   assign w_last_unit = (r_remain <= 4'd1);
   assign w_rem_dec   = r_remain - 4'd1;
   assign w_rem_inc   = (r_remain == 4'd15) ? 4'd15 : r_remain + 4'd1;

   // Sequencer state, prescaler, beep timer, edge-detect history and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_p          <= 1'b0;
         r_beep       <= 1'b0;
         r_remain     <= 4'd0;
         r_pre        <= {PW{1'b0}};
         r_bcnt       <= {BW{1'b0}};
         r_set_prev   <= 1'b0;
         r_start_prev <= 1'b0;
         r_stop_prev  <= 1'b0;
      end else begin
         r_set_prev   <= set;
         r_start_prev <= start;
         r_stop_prev  <= stop;
         case (r_state)
            ST_IDLE: begin
               r_p      <= 1'b0;
               r_beep   <= 1'b0;
               r_remain <= 4'd0;
               if (w_set_ev && (tin != 4'd0)) begin
                  r_state  <= ST_SET;
                  r_remain <= tin;
               end
            end
            ST_SET: begin
               if (w_stop_ev) begin
                  r_state  <= ST_IDLE;
                  r_remain <= 4'd0;
               end else if (w_start_ev && !door) begin
                  r_state <= ST_COOK;
                  r_p     <= 1'b1;
                  r_pre   <= {PW{1'b0}};
               end else if (w_set_ev) begin
                  r_remain <= tin;
                  if (tin == 4'd0) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_COOK: begin
               // A pause swallows this cycle's tick; a quick-add on the terminal tick nets to zero.
               if (door || w_stop_ev) begin
                  r_state <= ST_PAUSE;
                  r_p     <= 1'b0;
               end else begin
                  r_pre <= w_pre_nxt;
                  if (w_start_ev) begin
                     if (!w_term) begin
                        r_remain <= w_rem_inc;
                     end
                  end else if (w_term) begin
                     if (w_last_unit) begin
                        r_state  <= ST_DONE;
                        r_p      <= 1'b0;
                        r_beep   <= 1'b1;
                        r_bcnt   <= {BW{1'b0}};
                        r_remain <= 4'd0;
                     end else begin
                        r_remain <= w_rem_dec;
                     end
                  end
               end
            end
            ST_PAUSE: begin
               // The resume edge counts as a cook cycle, making up for the tick lost at pause.
               if (w_stop_ev) begin
                  r_state  <= ST_IDLE;
                  r_remain <= 4'd0;
                  r_pre    <= {PW{1'b0}};
               end else if (w_start_ev && !door) begin
                  r_state <= ST_COOK;
                  r_p     <= 1'b1;
                  r_pre   <= w_pre_nxt;
                  if (w_term) begin
                     if (w_last_unit) begin
                        r_state  <= ST_DONE;
                        r_p      <= 1'b0;
                        r_beep   <= 1'b1;
                        r_bcnt   <= {BW{1'b0}};
                        r_remain <= 4'd0;
                     end else begin
                        r_remain <= w_rem_dec;
                     end
                  end
               end
            end
            ST_DONE: begin
               if (w_stop_ev || door || (r_bcnt == BEEP_LAST)) begin
                  r_state <= ST_IDLE;
                  r_beep  <= 1'b0;
                  r_bcnt  <= {BW{1'b0}};
               end else begin
                  r_bcnt <= r_bcnt + BW'(1);
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_p      <= 1'b0;
               r_beep   <= 1'b0;
               r_remain <= 4'd0;
               r_pre    <= {PW{1'b0}};
               r_bcnt   <= {BW{1'b0}};
            end
         endcase
      end
   end

   assign p      = r_p;
   assign remain = r_remain;
   assign beep   = r_beep;
   assign state  = r_state;
endmodule

// File: doc/microwave_ctrl.md
# microwave_ctrl

Sequencing controller for the microwave-range cook timer. Loads a 4-bit cook time and counts it down one unit per prescaled tick while the magnetron enable `p` is high. Handles door interlock, pause/resume, cancel and quick-add, and raises a timed completion beep. Sits between the front-panel debouncers and the magnetron/beeper drivers. It replaces the free-running two-clock timer arrangement with a single-clock FSM.

## Interface
- `TICK_DIV`, 4: clock cycles per countdown unit; ≥2.
- `BEEP_LEN`, 3: beep duration in countdown units; ≥1.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `tin` in 4: cook time to load, in units.
- `set` in 1: load request, rising-edge detected.
- `start` in 1: start/resume/quick-add, rising-edge detected.
- `stop` in 1: pause/cancel, rising-edge detected.
- `door` in 1: 1 = door open (level).
- `p` out 1: magnetron enable, registered.
- `remain` out 4: remaining units, registered.
- `beep` out 1: completion beeper, registered.
- `state` out 3: current FSM state code.

## Operation
- Edge detect: `set`, `start` and `stop` each have a prev-register, reset to 0. An event is input & ~prev. Holding an input high yields exactly one event.
- Event priority within a cycle: door open > stop > start > set.
- IDLE (000): `remain`=0.
  - set with `tin`≠0 → SET, `remain`←`tin`.
  - set with `tin`=0 is ignored.
- SET (001):
  - set reloads `remain`←`tin`; `tin`=0 → IDLE, `remain`←0.
  - start with door closed → COOK, prescaler←0.
  - start with door open is ignored.
  - stop → IDLE, `remain`←0.
- COOK (010): `p`=1.
  - Prescaler counts 0..TICK_DIV-1. At terminal count it wraps and `remain` decrements.
  - Decrement from 1 → DONE, `remain`=0.
  - Door open or stop → PAUSE. Prescaler holds its value; the tick in that cycle is suppressed.
  - start → `remain`+1, saturating at 15. Prescaler is unaffected.
  - If start and the terminal tick coincide, the net change to `remain` is 0.
- PAUSE (011): `p`=0, prescaler held.
  - start with door closed → COOK; prescaler resumes from the held value.
  - stop → IDLE, `remain`←0, prescaler←0.
  - set is ignored.
- DONE (100): `beep`=1 for BEEP_LEN×TICK_DIV cycles, then → IDLE.
  - stop or door open → IDLE immediately, `beep`←0.
  - start/set are ignored.
- Codes 101–111 are illegal and recover to IDLE on the next edge with all outputs cleared.
- Arithmetic:
  - `remain` never underflows; decrement occurs only when `remain`≥1.
  - Prescaler width is clog2(TICK_DIV). Beep counter width covers BEEP_LEN×TICK_DIV.

## Timing
- Reset asserted: `state`=IDLE, `p`=0, `remain`=0, `beep`=0, prescaler=0, beep counter=0, edge prev-regs=0. Applies immediately, independent of `clk`.
- All state and outputs update on the same edge as the causing event; there is zero added latency from the edge detectors.
- `p` rises on the edge that samples start and falls on the edge that samples door open, stop, or the final tick.
- The first decrement occurs TICK_DIV edges after COOK entry.
- An uninterrupted cook keeps `p` high for exactly `remain`×TICK_DIV cycles.
- DONE entry: `p`←0 and `beep`←1 on the same edge. `beep` stays high exactly BEEP_LEN×TICK_DIV cycles.
- Reset mid-COOK: `p` drops asynchronously; there is no beep and no resume.

## Test plan
- Basic cook (TICK_DIV=4, BEEP_LEN=3):
  - Stimulus: set with `tin`=3, then start.
  - Response: `p` high exactly 12 cycles; `remain` steps 3→2→1→0 every 4 cycles; `beep` high 12 cycles; back to IDLE.
- Door interlock:
  - Stimulus: door opens 6 cycles into a `tin`=3 cook, closes, then start.
  - Response: `p` drops the same edge, `remain`=2 held, state=011. After resume, the next decrement comes 2 cycles later (prescaler held at 1); total `p`-high = 12.
- Cancel:
  - Stimulus: stop in COOK, then stop again in PAUSE.
  - Response: PAUSE, then IDLE with `remain`=0.
  - Stimulus: start with door open in SET.
  - Response: stays in SET, `p`=0.
- Quick-add and saturation:
  - Stimulus: start pulses in COOK with `remain`=14.
  - Response: 15, then 15.
  - Stimulus: start coinciding with the terminal tick.
  - Response: `remain` unchanged.
  - Stimulus: start held high 10 cycles.
  - Response: only +1.
- Boundaries:
  - Stimulus: set with `tin`=0.
  - Response: stays IDLE.
  - Stimulus: door open during DONE.
  - Response: `beep` 0 next edge, IDLE.
  - Stimulus: `rst` low mid-cook.
  - Response: all outputs 0 asynchronously.
